// File: rtl/alu_divider.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH cycles per division.
// Define ALU_DIVIDER_SIGNED_EN to honour sign_op (two's-complement, truncating toward zero).
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH+1:0] shifted, diff;
    logic             borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next, quo_final, rem_final;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;

`ifdef ALU_DIVIDER_SIGNED_EN
    logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
`else
    logic unused_sign_op;
    assign unused_sign_op = sign_op;
`endif

    // One restoring step; the extra top bit of shifted turns the subtract's MSB into the borrow.
    always_comb begin
        shifted      = {rem_q, quo_q[WIDTH-1]};
        diff         = shifted - {2'b00, div_q};
        borrow       = diff[WIDTH+1];
        rem_next     = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
        quo_next     = {quo_q[WIDTH-2:0], ~borrow};
        quo_final    = quo_next;
        rem_final    = rem_next[WIDTH-1:0];
        dividend_mag = dividend;
        divisor_mag  = divisor;
`ifdef ALU_DIVIDER_SIGNED_EN
        if (neg_q_q) quo_final = -quo_next;
        if (neg_r_q) rem_final = -rem_next[WIDTH-1:0];
        if (sign_op && dividend[WIDTH-1]) dividend_mag = -dividend;
        if (sign_op && divisor[WIDTH-1])  divisor_mag  = -divisor;
`endif
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef ALU_DIVIDER_SIGNED_EN
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dbz_d = 1'b0;
                    cnt_d = CW'(WIDTH - 1);
                    div_d = divisor_mag;
                    quo_d = dividend_mag;
                    rem_d = '0;
`ifdef ALU_DIVIDER_SIGNED_EN
                    neg_q_d = sign_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_d = sign_op && dividend[WIDTH-1];
`endif
                    // Zero divisor bypasses the iterations and reports the raw dividend.
                    if (divisor == '0) begin
                        state_d     = DONE;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next;
                quo_d = quo_next;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = quo_final;
                    remainder_d = rem_final;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef ALU_DIVIDER_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef ALU_DIVIDER_SIGNED_EN
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
`endif
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
